// File: rtl/modop_pkg.sv
// Shared definitions for the modop arithmetic blocks (modadd, modsub_pipe):
// default widths, width helper types and construction of the odd modulus q.
package modop_pkg;

  localparam int LOGQ_DEF  = 64;
  localparam int LOGQH_DEF = 47;
  localparam int QMAX      = 128;

  typedef logic [LOGQ_DEF-1:0] word_t;
  typedef logic [LOGQ_DEF:0]   dword_t;

  // q = {qH, zeros, 1'b1}: qH shifted to the top of a logq-bit word, LSB forced to 1.
  function automatic logic [QMAX-1:0] make_q(input logic [QMAX-1:0] qh,
                                             input int              logq,
                                             input int              logqh);
    logic [QMAX-1:0] q;
    q    = qh << (logq - logqh);
    q[0] = 1'b1;
    return q;
  endfunction

endpackage

// File: rtl/modop_pipe_reg.sv
// Elastic single-entry register slice with valid/ready handshake; collapses to
// wires when EN=0 so pipeline depth can be tuned without touching the datapath.
module modop_pipe_reg #(
  parameter int W        = 8,
  parameter bit EN       = 1'b1,
  parameter bit RST_DATA = 1'b0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         up_valid,
  output logic         up_ready,
  input  logic [W-1:0] up_data,
  output logic         dn_valid,
  input  logic         dn_ready,
  output logic [W-1:0] dn_data
);

  generate
    if (EN) begin : g_reg
      logic         valid_reg;
      logic [W-1:0] data_reg;

      always_ff @(posedge clk) begin
        if (rst) begin
          valid_reg <= 1'b0;
        end else if (up_ready) begin
          valid_reg <= up_valid;
        end
      end

      // Data only moves on a real transfer, so a stalled result stays put.
      always_ff @(posedge clk) begin
        if (rst && RST_DATA) begin
          data_reg <= '0;
        end else if (up_ready && up_valid) begin
          data_reg <= up_data;
        end
      end

      assign up_ready = ~valid_reg | dn_ready;
      assign dn_valid = valid_reg;
      assign dn_data  = data_reg;
    end else begin : g_bypass
      logic unused_bypass;
      assign unused_bypass = clk ^ rst;

      assign up_ready = dn_ready;
      assign dn_valid = up_valid;
      assign dn_data  = up_data;
    end
  endgenerate

endmodule

// File: rtl/modsub_pipe.sv
// Pipelined elastic modular subtractor C = (A - B) mod q, with q rebuilt per
// operation from the qH bits that travel alongside each operand pair.
module modsub_pipe
  import modop_pkg::*;
#(
  parameter int LOGQ   = 64,
  parameter int LOGQH  = 47,
  parameter int FF_IN  = 1,
  parameter int FF_SUB = 1,
  parameter int FF_OUT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [LOGQ-1:0]  A,
  input  logic [LOGQ-1:0]  B,
  input  logic [LOGQH-1:0] qH,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [LOGQ-1:0]  C
);

  localparam int LAT = FF_IN + FF_SUB + FF_OUT;
  localparam int W1  = LOGQH + 2 * LOGQ;
  localparam int W2  = LOGQH + LOGQ + 1;

  logic            s1_up_ready;
  logic            s1_valid;
  logic [W1-1:0]   s1_data;
  logic            s2_up_ready;
  logic            s2_valid;
  logic [W2-1:0]   s2_data;
  logic            s3_up_ready;

  logic [LOGQ-1:0]  a1;
  logic [LOGQ-1:0]  b1;
  logic [LOGQH-1:0] qh1;
  logic [LOGQ:0]    d1;

  logic [LOGQ:0]         d2;
  logic [LOGQH-1:0]      qh2;
  logic [LOGQ-1:0]       q2;
  logic [QMAX-LOGQ-1:0]  q_hi_unused;
  logic [LOGQ-1:0]       sum2;
  logic [LOGQ-1:0]       c2;

  modop_pipe_reg #(.W(W1), .EN(FF_IN != 0), .RST_DATA(1'b0)) u_in_stage (
    .clk      (clk),
    .rst      (rst),
    .up_valid (in_valid),
    .up_ready (s1_up_ready),
    .up_data  ({qH, B, A}),
    .dn_valid (s1_valid),
    .dn_ready (s2_up_ready),
    .dn_data  (s1_data)
  );

  // Raw subtraction one bit wider than the operands; the top bit is the borrow.
  assign a1  = s1_data[LOGQ-1:0];
  assign b1  = s1_data[2*LOGQ-1:LOGQ];
  assign qh1 = s1_data[W1-1:2*LOGQ];
  assign d1  = {1'b0, a1} - {1'b0, b1};

  modop_pipe_reg #(.W(W2), .EN(FF_SUB != 0), .RST_DATA(1'b0)) u_sub_stage (
    .clk      (clk),
    .rst      (rst),
    .up_valid (s1_valid),
    .up_ready (s2_up_ready),
    .up_data  ({qh1, d1}),
    .dn_valid (s2_valid),
    .dn_ready (s3_up_ready),
    .dn_data  (s2_data)
  );

  // On borrow, adding q wraps the negative difference back into [0,q).
  assign d2   = s2_data[LOGQ:0];
  assign qh2  = s2_data[W2-1:LOGQ+1];
  assign {q_hi_unused, q2} = make_q(QMAX'(qh2), LOGQ, LOGQH);
  assign sum2 = d2[LOGQ-1:0] + q2;
  assign c2   = d2[LOGQ] ? sum2 : d2[LOGQ-1:0];

  modop_pipe_reg #(.W(LOGQ), .EN(FF_OUT != 0), .RST_DATA(1'b1)) u_out_stage (
    .clk      (clk),
    .rst      (rst),
    .up_valid (s2_valid),
    .up_ready (s3_up_ready),
    .up_data  (c2),
    .dn_valid (out_valid),
    .dn_ready (out_ready),
    .dn_data  (C)
  );

  generate
    if (LAT == 0) begin : g_comb_ready
      assign in_ready = s1_up_ready;
    end else begin : g_reg_ready
      assign in_ready = s1_up_ready & ~rst;
    end
  endgenerate

endmodule

// File: tb/tb_modsub_pipe.sv
// Bench for modsub_pipe: directed boundary cases, latency on three pipeline
// configurations, randomized elastic traffic against a queue-based model.
module tb_modsub_pipe;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [2:0]  iv = 3'b000;
  logic [2:0]  ir;
  logic [2:0]  ov;
  logic        ordy = 1'b0;
  logic [63:0] a_in = '0;
  logic [63:0] b_in = '0;
  logic [46:0] qh_in = '0;
  logic [63:0] cc [3];

  int total = 0;
  int bad   = 0;
  int n_acc = 0;
  int n_out = 0;
  logic [63:0] expq [$];
  bit          hold_pending = 1'b0;
  logic [63:0] held_c = '0;
  bit          last_ir = 1'b0;

  localparam logic [46:0] QH_T = 47'h400008C00000;

  always #5 clk = ~clk;

  modsub_pipe u_dut (
    .clk(clk), .rst(rst), .in_valid(iv[0]), .in_ready(ir[0]),
    .A(a_in), .B(b_in), .qH(qh_in),
    .out_valid(ov[0]), .out_ready(ordy), .C(cc[0])
  );

  modsub_pipe #(.FF_IN(0), .FF_SUB(0), .FF_OUT(0)) u_lat0 (
    .clk(clk), .rst(rst), .in_valid(iv[1]), .in_ready(ir[1]),
    .A(a_in), .B(b_in), .qH(qh_in),
    .out_valid(ov[1]), .out_ready(ordy), .C(cc[1])
  );

  modsub_pipe #(.FF_SUB(0)) u_nosub (
    .clk(clk), .rst(rst), .in_valid(iv[2]), .in_ready(ir[2]),
    .A(a_in), .B(b_in), .qH(qh_in),
    .out_valid(ov[2]), .out_ready(ordy), .C(cc[2])
  );

  function automatic logic [63:0] qof(input logic [46:0] qh);
    return {qh, 16'b0, 1'b1};
  endfunction

  function automatic logic [63:0] ref_sub(input logic [63:0] a, input logic [63:0] b,
                                          input logic [46:0] qh);
    if (a >= b) return a - b;
    return qof(qh) - (b - a);
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
    end
  endtask

  task automatic rand_op(input logic [46:0] qh);
    logic [63:0] q;
    qh_in = qh;
    q     = qof(qh);
    a_in  = {$urandom(), $urandom()} % q;
    b_in  = {$urandom(), $urandom()} % q;
  endtask

  task automatic rand_qh();
    logic [63:0] r;
    r = {$urandom(), $urandom()};
    rand_op(r[46:0]);
  endtask

  // One clock of the main DUT with scoreboarding; inputs are already driven.
  task automatic cyc();
    @(negedge clk);
    last_ir = ir[0];
    if (hold_pending) begin
      chk("hold_valid", 64'(ov[0]), 64'd1);
      chk("hold_stable", cc[0], held_c);
    end
    hold_pending = 1'b0;
    if (ov[0]) begin
      if (ordy) begin
        n_out++;
        $display("out c=%h", cc[0]);
        if (expq.size() == 0) chk("spurious_out", 64'(ov[0]), 64'd0);
        else chk("result", cc[0], expq.pop_front());
      end else begin
        hold_pending = 1'b1;
        held_c       = cc[0];
      end
    end
    if (iv[0] && ir[0]) begin
      n_acc++;
      expq.push_back(ref_sub(a_in, b_in, qh_in));
      $display("in  a=%h b=%h qh=%h", a_in, b_in, qh_in);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    iv  = 3'b000;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    expq.delete();
    hold_pending = 1'b0;
  endtask

  task automatic lat_check(input int which, input logic [63:0] a, input logic [63:0] b,
                           input logic [63:0] exp, input int explat, input string tag);
    int n;
    ordy  = 1'b1;
    a_in  = a;
    b_in  = b;
    qh_in = QH_T;
    iv    = 3'b000;
    iv[which] = 1'b1;
    @(negedge clk);
    chk({tag, "_in_ready"}, 64'(ir[which]), 64'd1);
    n = 0;
    while (!ov[which] && n < 10) begin
      @(posedge clk);
      #1;
      iv = 3'b000;
      n++;
      @(negedge clk);
    end
    $display("lat %s c=%h cycles=%0d", tag, cc[which], n);
    chk({tag, "_latency"}, 64'(n), 64'(explat));
    chk({tag, "_c"}, cc[which], exp);
    @(posedge clk);
    #1;
    iv = 3'b000;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt;
    int guard;

    // Reset state
    @(negedge clk);
    chk("rst_in_ready", 64'(ir[0]), 64'd0);
    chk("rst_out_valid", 64'(ov[0]), 64'd0);
    chk("rst_c", cc[0], 64'd0);
    chk("rst_out_valid_nosub", 64'(ov[2]), 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("in_ready_after_rst", 64'(ir[0]), 64'd1);
    @(posedge clk);
    #1;

    // Tests 1-2 on each configuration
    lat_check(0, 64'h1000000000000005, 64'h010000000000000A, 64'h0EFFFFFFFFFFFFFB, 3, "t1_lat3");
    lat_check(0, 64'h010000000000000A, 64'h1000000000000005, 64'h7100118000000006, 3, "t2_lat3");
    lat_check(1, 64'h1000000000000005, 64'h010000000000000A, 64'h0EFFFFFFFFFFFFFB, 0, "t1_lat0");
    lat_check(1, 64'h010000000000000A, 64'h1000000000000005, 64'h7100118000000006, 0, "t2_lat0");
    lat_check(2, 64'h1000000000000005, 64'h010000000000000A, 64'h0EFFFFFFFFFFFFFB, 2, "t1_lat2");
    lat_check(2, 64'h010000000000000A, 64'h1000000000000005, 64'h7100118000000006, 2, "t2_lat2");

    // LAT=0 ready/valid are straight wires
    ordy = 1'b0;
    iv   = 3'b010;
    @(negedge clk);
    chk("lat0_ready_follows", 64'(ir[1]), 64'd0);
    chk("lat0_valid_follows", 64'(ov[1]), 64'd1);
    @(posedge clk);
    #1;
    iv = 3'b000;

    // Test 3: boundaries and back-to-back qH changes
    do_reset();
    ordy = 1'b1;
    iv   = 3'b001;
    a_in = 64'h1234; b_in = 64'h1234; qh_in = QH_T;
    cyc();
    a_in = 64'h0; b_in = 64'h1;
    cyc();
    a_in = 64'h0; b_in = 64'h1; qh_in = 47'h000000000001;
    cyc();
    a_in = 64'h5; b_in = 64'h7; qh_in = 47'h7FFFFFFFFFFF;
    cyc();
    iv = 3'b000;
    repeat (4) cyc();
    chk("t3_drained", 64'(expq.size()), 64'd0);

    // Test 4: random traffic with random stalls
    cnt   = n_acc;
    guard = 0;
    rand_qh();
    while ((n_acc - cnt) < 100 && guard < 2000) begin
      iv[0] = 1'($urandom_range(0, 1));
      ordy  = 1'($urandom_range(0, 1));
      cyc();
      if (last_ir && iv[0]) rand_qh();
      guard++;
    end
    chk("t4_accept_count", 64'(n_acc - cnt), 64'd100);
    iv[0] = 1'b0;
    ordy  = 1'b1;
    guard = 0;
    while (expq.size() != 0 && guard < 20) begin
      cyc();
      guard++;
    end
    chk("t4_drained", 64'(expq.size()), 64'd0);

    // Test 5: fill with out_ready low, then drain and stream
    do_reset();
    ordy  = 1'b0;
    iv[0] = 1'b1;
    cnt   = n_acc;
    rand_op(QH_T);
    repeat (6) begin
      cyc();
      if (last_ir) rand_op(QH_T);
    end
    chk("t5_fill_accepts", 64'(n_acc - cnt), 64'd3);
    chk("t5_full_in_ready", 64'(last_ir), 64'd0);
    iv[0] = 1'b0;
    ordy  = 1'b1;
    cnt   = n_out;
    repeat (3) cyc();
    chk("t5_drain_count", 64'(n_out - cnt), 64'd3);
    cnt = n_acc;
    iv[0] = 1'b1;
    repeat (10) begin
      cyc();
      rand_op(QH_T);
    end
    chk("t5_stream_accepts", 64'(n_acc - cnt), 64'd10);
    iv[0] = 1'b0;
    cnt   = n_out;
    repeat (3) cyc();
    chk("t5_stream_tail", 64'(n_out - cnt), 64'd3);
    chk("t5_drained", 64'(expq.size()), 64'd0);

    // Test 6: reset with operands in flight
    ordy  = 1'b0;
    iv[0] = 1'b1;
    rand_op(QH_T);
    cyc();
    rand_op(QH_T);
    cyc();
    iv[0] = 1'b0;
    repeat (2) cyc();
    chk("t6_inflight_visible", 64'(ov[0]), 64'd1);
    rst = 1'b1;
    @(negedge clk);
    chk("t6_rst_in_ready", 64'(ir[0]), 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("t6_out_valid", 64'(ov[0]), 64'd0);
    chk("t6_c_zero", cc[0], 64'd0);
    @(posedge clk);
    #1;
    expq.delete();
    hold_pending = 1'b0;
    ordy = 1'b1;
    cnt  = n_out;
    repeat (6) cyc();
    chk("t6_no_stale", 64'(n_out - cnt), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
